// File: rtl/sonic_tx_pkg.sv
// Shared widths, framing constants and types for the TX 66-bit ring path.
package sonic_tx_pkg;
    localparam int BLOCK_W          = 66;
    localparam int WORD_W           = 128;
    localparam int ACC_W            = 194;
    localparam int WORDS_PER_FRAME  = 33;
    localparam int BLOCKS_PER_FRAME = 64;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [ACC_W-1:0]   acc_t;
endpackage

// File: rtl/sonic_tx_ring_ptr.sv
// TX ring read pointer: counts consumed words, wraps at the ring size, and
// skips to the next frame boundary whenever the transmitter is disabled.
module sonic_tx_ring_ptr
    import sonic_tx_pkg::*;
#(
    parameter int RING_DEPTH = 7920,
    parameter int PTR_WIDTH  = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic                 i_tx_ena,
    output logic [PTR_WIDTH-1:0] o_rptr
);
    localparam logic [PTR_WIDTH:0]   DEPTH_W = (PTR_WIDTH+1)'(RING_DEPTH);
    localparam logic [PTR_WIDTH-1:0] DEPTH_L = PTR_WIDTH'(RING_DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST    = PTR_WIDTH'(RING_DEPTH - 1);
    localparam logic [5:0]           WLAST   = 6'(WORDS_PER_FRAME - 1);
    localparam logic [5:0]           WPF     = 6'(WORDS_PER_FRAME);

    logic [PTR_WIDTH-1:0] r_rptr;
    logic [5:0]           r_widx;
    logic [5:0]           w_skip;
    logic [PTR_WIDTH:0]   w_sum;
    logic [PTR_WIDTH-1:0] w_diff;
    logic [PTR_WIDTH-1:0] w_bound;

    // Words left in the current frame, added one bit wider so it cannot overflow
    assign w_skip  = WPF - r_widx;
    assign w_sum   = {1'b0, r_rptr} + {{(PTR_WIDTH-5){1'b0}}, w_skip};
    assign w_diff  = w_sum[PTR_WIDTH-1:0] - DEPTH_L;
    assign w_bound = (w_sum >= DEPTH_W) ? w_diff : w_sum[PTR_WIDTH-1:0];

    // Pointer/word-index update: disable realigns to a frame, push advances
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rptr <= '0;
            r_widx <= '0;
        end else if (!i_tx_ena) begin
            if (r_widx != '0) begin
                r_rptr <= w_bound;
                r_widx <= '0;
            end
        end else if (i_push) begin
            r_rptr <= (r_rptr == LAST)  ? '0 : r_rptr + 1'b1;
            r_widx <= (r_widx == WLAST) ? '0 : r_widx + 1'b1;
        end
    end

    assign o_rptr = r_rptr;
endmodule

// File: rtl/sonic_tx_ctl_66.sv
// Unpacks 128-bit TX ring words into a continuous stream of 66-bit blocks
// and exports the ring read pointer.
module sonic_tx_ctl_66
    import sonic_tx_pkg::*;
#(
    parameter int RING_DEPTH = 7920,
    parameter int PTR_WIDTH  = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_ena,
    input  logic [WORD_W-1:0]    data_in,
    input  logic                 wrreq,
    output logic                 wr_ready,
    output logic [BLOCK_W-1:0]   data_out,
    output logic                 data_valid,
    input  logic                 rdreq,
    output logic                 underflow,
    output logic [PTR_WIDTH-1:0] tx_ring_rptr
);
    localparam logic [7:0] BLK8  = 8'(BLOCK_W);
    localparam logic [7:0] WORD8 = 8'(WORD_W);

    acc_t       r_acc;
    logic [7:0] r_cnt;
    logic       r_uf;

    logic       w_pop;
    logic       w_push;
    acc_t       w_acc_p;
    logic [7:0] w_cnt_p;
    acc_t       w_acc_n;
    logic [7:0] w_cnt_n;

    assign data_valid = tx_ena && (r_cnt >= BLK8);
    assign wr_ready   = tx_ena && (r_cnt <= BLK8);
    assign w_pop      = rdreq && data_valid;
    assign w_push     = wrreq && wr_ready;

    // Pop first, then place the new word right above the surviving bits
    always_comb begin
        w_acc_p = r_acc;
        w_cnt_p = r_cnt;
        if (w_pop) begin
            w_acc_p = r_acc >> BLOCK_W;
            w_cnt_p = r_cnt - BLK8;
        end
        w_acc_n = w_acc_p;
        w_cnt_n = w_cnt_p;
        if (w_push) begin
            w_acc_n = w_acc_p | (acc_t'(data_in) << w_cnt_p);
            w_cnt_n = w_cnt_p + WORD8;
        end
    end

    // Accumulator state; a disabled transmitter drops any partial data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!tx_ena) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_n;
            r_cnt <= w_cnt_n;
        end
    end

    // Sticky underflow: a read with nothing to give is latched until reset
    always_ff @(posedge clock) begin
        if (reset)                    r_uf <= 1'b0;
        else if (rdreq && !data_valid) r_uf <= 1'b1;
    end

    sonic_tx_ring_ptr #(
        .RING_DEPTH (RING_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_ptr (
        .clock    (clock),
        .reset    (reset),
        .i_push   (w_push),
        .i_tx_ena (tx_ena),
        .o_rptr   (tx_ring_rptr)
    );

    assign data_out  = r_acc[BLOCK_W-1:0];
    assign underflow = r_uf;
endmodule

// File: tb/tb_sonic_tx_ctl_66.sv
// Self-checking bench for sonic_tx_ctl_66: a bit-level scoreboard of the
// expected block stream plus a reference model of handshake and pointer.
module tb_sonic_tx_ctl_66;
    localparam int DEPTH = 7920;

    logic         clock = 1'b0;
    logic         reset;
    logic         tx_ena;
    logic [127:0] data_in;
    logic         wrreq;
    logic         wr_ready;
    logic [65:0]  data_out;
    logic         data_valid;
    logic         rdreq;
    logic         underflow;
    logic [13:0]  tx_ring_rptr;

    int checks = 0;
    int failures = 0;

    logic [65:0] exp_q[$];
    bit          pend[$];
    int          m_rptr, m_widx;
    bit          m_uf;
    int          n_pops, n_push;
    logic [63:0] lf;

    always #5 clock = ~clock;

    sonic_tx_ctl_66 dut (
        .clock(clock), .reset(reset), .tx_ena(tx_ena), .data_in(data_in),
        .wrreq(wrreq), .wr_ready(wr_ready), .data_out(data_out),
        .data_valid(data_valid), .rdreq(rdreq), .underflow(underflow),
        .tx_ring_rptr(tx_ring_rptr)
    );

    function automatic int m_cnt();
        return exp_q.size() * 66 + pend.size();
    endfunction

    function automatic logic [127:0] lfsr_word();
        logic [127:0] w;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++)
                lf = {lf[62:0], lf[63] ^ lf[62] ^ lf[60] ^ lf[59]};
            w = {w[63:0], lf};
        end
        return w;
    endfunction

    // One clock: compare outputs against the model, then advance the model
    task automatic cyc(input bit ena, input bit wr, input bit rd,
                       input logic [127:0] d, output bit acc);
        bit mv, mr;
        logic [65:0] b;
        tx_ena = ena; wrreq = wr; rdreq = rd; data_in = d;
        #1;
        mv = ena && (m_cnt() >= 66);
        mr = ena && (m_cnt() <= 66);
        checks += 4;
        if (data_valid !== mv) begin failures++; $display("FAIL cyc_valid got=%0b exp=%0b t=%0t", data_valid, mv, $time); end
        if (wr_ready !== mr)   begin failures++; $display("FAIL cyc_ready got=%0b exp=%0b t=%0t", wr_ready, mr, $time); end
        if (underflow !== m_uf) begin failures++; $display("FAIL cyc_uf got=%0b exp=%0b t=%0t", underflow, m_uf, $time); end
        if (tx_ring_rptr !== 14'(m_rptr)) begin failures++; $display("FAIL cyc_rptr got=%0d exp=%0d t=%0t", tx_ring_rptr, m_rptr, $time); end
        if (rd && mv) begin
            b = exp_q.pop_front();
            n_pops++;
            checks++;
            if (data_out !== b) begin failures++; $display("FAIL sb_block got=%h exp=%h t=%0t", data_out, b, $time); end
        end
        acc = wr && mr;
        if (acc) begin
            n_push++;
            for (int i = 0; i < 128; i++) pend.push_back(d[i]);
            while (pend.size() >= 66) begin
                for (int j = 0; j < 66; j++) b[j] = pend.pop_front();
                exp_q.push_back(b);
            end
            m_rptr = (m_rptr + 1) % DEPTH;
            m_widx = (m_widx + 1) % 33;
        end
        if (rd && !mv) m_uf = 1;
        if (!ena) begin
            exp_q.delete(); pend.delete();
            if (m_widx != 0) begin
                m_rptr = (m_rptr + 33 - m_widx) % DEPTH;
                m_widx = 0;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1; tx_ena = 0; wrreq = 0; rdreq = 0; data_in = '0;
        @(negedge clock); @(negedge clock);
        reset = 0;
        exp_q.delete(); pend.delete();
        m_rptr = 0; m_widx = 0; m_uf = 0; n_pops = 0; n_push = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 5;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", data_valid); end
        if (wr_ready !== 1'b0)   begin failures++; $display("FAIL rst_ready got=%0b exp=0", wr_ready); end
        if (data_out !== 66'd0)  begin failures++; $display("FAIL rst_dout got=%h exp=0", data_out); end
        if (tx_ring_rptr !== 14'd0) begin failures++; $display("FAIL rst_rptr got=%0d exp=0", tx_ring_rptr); end
        if (underflow !== 1'b0)  begin failures++; $display("FAIL rst_uf got=%0b exp=0", underflow); end
    endtask

    task automatic test_single();
        logic [127:0] w;
        bit a;
        w = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        do_reset();
        cyc(1, 1, 0, w, a);
        #1;
        checks += 2;
        if (data_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", data_valid); end
        if (data_out !== w[65:0]) begin failures++; $display("FAIL single_dout got=%h exp=%h", data_out, w[65:0]); end
        cyc(1, 0, 1, '0, a);
        #1;
        checks += 2;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%0b exp=0", data_valid); end
        if (wr_ready !== 1'b1)   begin failures++; $display("FAIL single_pop_ready got=%0b exp=1", wr_ready); end
    endtask

    task automatic test_frame();
        logic [127:0] w;
        bit a;
        int guard;
        do_reset();
        lf = 64'hACE1_2468_1357_9BDF;
        w = lfsr_word();
        guard = 0;
        while ((n_push < 33 || exp_q.size() != 0) && guard < 400) begin
            cyc(1, n_push < 33, m_cnt() >= 66, w, a);
            if (a) w = lfsr_word();
            guard++;
        end
        #1;
        checks += 6;
        if (guard >= 400) begin failures++; $display("FAIL frame_timeout got=%0d exp<400", guard); end
        if (n_pops !== 64) begin failures++; $display("FAIL frame_blocks got=%0d exp=64", n_pops); end
        if (pend.size() != 0 || data_valid !== 1'b0 || wr_ready !== 1'b1)
            begin failures++; $display("FAIL frame_empty valid=%0b ready=%0b exp 0/1", data_valid, wr_ready); end
        if (tx_ring_rptr !== 14'd33) begin failures++; $display("FAIL frame_rptr got=%0d exp=33", tx_ring_rptr); end
        if (underflow !== 1'b0) begin failures++; $display("FAIL frame_uf got=%0b exp=0", underflow); end
        // Disable at a boundary must not move the pointer
        cyc(0, 0, 0, '0, a);
        #1;
        if (tx_ring_rptr !== 14'd33) begin failures++; $display("FAIL frame_noskip got=%0d exp=33", tx_ring_rptr); end
    endtask

    task automatic test_backpressure();
        bit a;
        int accepted = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555 + 128'(i), a);
            if (a) accepted++;
        end
        #1;
        checks += 3;
        if (accepted !== 1) begin failures++; $display("FAIL bp_accepted got=%0d exp=1", accepted); end
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0b exp=0", wr_ready); end
        if (data_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", data_valid); end
        cyc(1, 0, 1, '0, a);
        #1;
        checks += 2;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%0b exp=1", wr_ready); end
        if (data_valid !== 1'b0) begin failures++; $display("FAIL bp_valid2 got=%0b exp=0", data_valid); end
    endtask

    task automatic test_underflow();
        bit a;
        do_reset();
        cyc(1, 0, 1, '0, a);
        #1;
        checks++;
        if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b exp=1", underflow); end
        for (int i = 0; i < 6; i++) cyc(1, 1, m_cnt() >= 66, 128'(i) * 128'h1234_5678_9ABC, a);
        #1;
        checks++;
        if (underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b exp=1", underflow); end
        // Reset while enabled and mid-frame
        reset = 1; tx_ena = 1;
        @(posedge clock); @(negedge clock);
        #1;
        checks += 3;
        if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%0b exp=0", underflow); end
        if (tx_ring_rptr !== 14'd0) begin failures++; $display("FAIL midrst_rptr got=%0d exp=0", tx_ring_rptr); end
        if (data_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", data_valid); end
        reset = 0;
    endtask

    task automatic test_ena_drop();
        logic [127:0] w;
        bit a;
        int guard = 0;
        do_reset();
        while (n_push < 5 && guard < 50) begin
            cyc(1, 1, m_cnt() >= 66, 128'h5555_0000_AAAA_FFFF_0F0F_F0F0_1234_0000 + 128'(n_push), a);
            guard++;
        end
        cyc(0, 0, 0, '0, a);
        #1;
        checks += 2;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL drop_valid got=%0b exp=0", data_valid); end
        if (tx_ring_rptr !== 14'd33) begin failures++; $display("FAIL drop_rptr got=%0d exp=33", tx_ring_rptr); end
        w = 128'hFEED_FACE_CAFE_BABE_0BAD_F00D_8BAD_F00D;
        cyc(1, 1, 0, w, a);
        #1;
        checks += 2;
        if (tx_ring_rptr !== 14'd34) begin failures++; $display("FAIL reena_rptr got=%0d exp=34", tx_ring_rptr); end
        if (data_out !== w[65:0]) begin failures++; $display("FAIL reena_dout got=%h exp=%h", data_out, w[65:0]); end
    endtask

    task automatic test_wrap();
        bit a, wr, rd, saw_wrap;
        int guard = 0;
        int prev;
        do_reset();
        saw_wrap = 0;
        while ((n_push < 240 * 33 || exp_q.size() != 0) && guard < 60000) begin
            wr = (n_push < 240 * 33) && ($urandom_range(0, 4) != 0);
            rd = (m_cnt() >= 66) && ($urandom_range(0, 5) != 0);
            prev = m_rptr;
            cyc(1, wr, rd, {$urandom, $urandom, $urandom, $urandom}, a);
            if (prev == DEPTH - 1 && m_rptr == 0) saw_wrap = 1;
            guard++;
        end
        #1;
        checks += 5;
        if (guard >= 60000) begin failures++; $display("FAIL wrap_timeout got=%0d exp<60000", guard); end
        if (!saw_wrap) begin failures++; $display("FAIL wrap_seen got=0 exp=1"); end
        if (tx_ring_rptr !== 14'd0) begin failures++; $display("FAIL wrap_rptr got=%0d exp=0", tx_ring_rptr); end
        if (n_pops !== 240 * 64) begin failures++; $display("FAIL wrap_blocks got=%0d exp=%0d", n_pops, 240 * 64); end
        if (underflow !== 1'b0) begin failures++; $display("FAIL wrap_uf got=%0b exp=0", underflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_backpressure();
        test_underflow();
        test_ena_drop();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
